pb_conditioner: RTL and testbench

Conditions raw asynchronous push-button / switch inputs into clean, synchronous control for the n-bit up/down counter datapath. Each channel is synchronized, debounced by a per-channel state machine, and turned into a debounced level, a one-cycle press pulse (with optional auto-repeat while held) and a one-cycle release pulse. Typical board wiring:
- press of the "step" button drives the counter's `enable`;
- press of the "load" button drives `load`;
- level of the "down" switch drives `dec`.

---
 rtl/pb_conditioner.sv | 136 +++++++++++++
 tb/tb_pb_conditioner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pb_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchronizer, debounce FSM and registered
// level / press (with optional auto-repeat) / release. `release` is a reserved word, hence release_pulse.

module pb_lane #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 25_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic release_pulse
);
   localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

   state_t        state, state_nxt;
   logic          s1, s;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
   logic [RW-1:0] rep_cnt, rep_nxt, rep_inc, rep_tgt;
   logic          armed, armed_nxt;
   logic          level_nxt, press_nxt, release_nxt;
   logic          done;

   // cnt is 0 in LOW/HIGH, so one compare covers both the entry and the waiting states
   assign cnt_inc = cnt + CW'(1);
   assign done    = (cnt_inc == CW'(DEBOUNCE_CYCLES));
   assign rep_inc = rep_cnt + RW'(1);
   assign rep_tgt = armed ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s  <= 1'b0;
      end else begin
         s1 <= btn_raw;
         s  <= s1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= LOW;
         cnt           <= '0;
         rep_cnt       <= '0;
         armed         <= 1'b0;
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         rep_cnt       <= rep_nxt;
         armed         <= armed_nxt;
         level         <= level_nxt;
         press         <= press_nxt;
         release_pulse <= release_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         LOW, WAIT_HIGH: begin
            if (!s)        state_nxt = LOW;
            else if (done) state_nxt = HIGH;
            else begin
               state_nxt = WAIT_HIGH;
               cnt_nxt   = cnt_inc;
            end
         end
         HIGH, WAIT_LOW: begin
            if (s)         state_nxt = HIGH;
            else if (done) state_nxt = LOW;
            else begin
               state_nxt = WAIT_LOW;
               cnt_nxt   = cnt_inc;
            end
         end
         default: state_nxt = LOW;
      endcase
   end

   // armed selects the repeat target: initial delay first, then the period
   always_comb begin
      level_nxt   = (state_nxt == HIGH) || (state_nxt == WAIT_LOW);
      press_nxt   = level_nxt && !level;
      release_nxt = level && !level_nxt;
      rep_nxt     = '0;
      armed_nxt   = 1'b0;
      if (REPEAT_DELAY > 0 && state == HIGH && state_nxt == HIGH) begin
         if (rep_inc == rep_tgt) begin
            press_nxt = 1'b1;
            armed_nxt = 1'b1;
         end else begin
            rep_nxt   = rep_inc;
            armed_nxt = armed;
         end
      end
   end
endmodule

module pb_conditioner #(
   parameter int W               = 1,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 25_000_000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] btn_raw,
   output logic [W-1:0] level,
   output logic [W-1:0] press,
   output logic [W-1:0] release_pulse
);
   for (genvar i = 0; i < W; i++) begin : g_lane
      pb_lane #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_lane (
         .clock        (clock),
         .reset        (reset),
         .btn_raw      (btn_raw[i]),
         .level        (level[i]),
         .press        (press[i]),
         .release_pulse(release_pulse[i])
      );
   end
endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner: debounce latency, bounce rejection, auto-repeat,
// glitch while held, async reset and simultaneous channels without repeat.

module tb_pb_conditioner;
   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] btn_raw, level, press, release_pulse;
   logic [1:0] btn_raw2, level2, press2, release2;
   int         checks = 0;
   int         errors = 0;

   always #5 clock = ~clock;

   pb_conditioner #(.W(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
      .clock(clock), .reset(reset), .btn_raw(btn_raw),
      .level(level), .press(press), .release_pulse(release_pulse));

   pb_conditioner #(.W(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)) dut_norep (
      .clock(clock), .reset(reset), .btn_raw(btn_raw2),
      .level(level2), .press(press2), .release_pulse(release2));

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] el, input logic [1:0] ep,
                            input logic [1:0] er);
      check({tag, " level"}, level, el);
      check({tag, " press"}, press, ep);
      check({tag, " release"}, release_pulse, er);
   endtask

   task automatic check_norep(input string tag, input logic [1:0] el, input logic [1:0] ep,
                              input logic [1:0] er);
      check({tag, " level2"}, level2, el);
      check({tag, " press2"}, press2, ep);
      check({tag, " release2"}, release2, er);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b0;
      btn_raw  = 2'b00;
      btn_raw2 = 2'b00;
      #2;
      check_all("reset_async", 2'b00, 2'b00, 2'b00);
      check_norep("reset_async", 2'b00, 2'b00, 2'b00);
      step();
      step();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_all($sformatf("idle k=%0d", k), 2'b00, 2'b00, 2'b00);
      end

      // clean press, auto-repeat at +10/+13/..., release after a long hold
      btn_raw = 2'b01;
      for (int k = 0; k <= 56; k++) begin
         step();
         check_all($sformatf("press_repeat k=%0d", k),
                   {1'b0, (k >= 5 && k <= 50)},
                   {1'b0, (k == 5 || (k >= 15 && k <= 45 && (k - 15) % 3 == 0))},
                   {1'b0, (k == 51)});
         if (k == 45) btn_raw = 2'b00;
      end

      // bounce 1,0,1,0 then low: nothing accepted
      btn_raw = 2'b01; step();
      btn_raw = 2'b00; step();
      btn_raw = 2'b01; step();
      btn_raw = 2'b00;
      for (int k = 0; k < 10; k++) begin
         step();
         check_all($sformatf("bounce k=%0d", k), 2'b00, 2'b00, 2'b00);
      end
      btn_raw = 2'b01;
      for (int k = 0; k <= 6; k++) begin
         step();
         check_all($sformatf("bounce_hold k=%0d", k), {1'b0, (k >= 5)}, {1'b0, (k == 5)}, 2'b00);
      end
      btn_raw = 2'b00;
      for (int k = 0; k <= 6; k++) begin
         step();
         check_all($sformatf("bounce_rel k=%0d", k), {1'b0, (k < 5)}, 2'b00, {1'b0, (k == 5)});
      end

      // pulse one cycle shorter than the debounce count is rejected
      btn_raw = 2'b01;
      for (int k = 0; k <= 10; k++) begin
         step();
         check_all($sformatf("short3 k=%0d", k), 2'b00, 2'b00, 2'b00);
         if (k == 2) btn_raw = 2'b00;
      end

      // pulse of exactly the debounce count is accepted
      btn_raw = 2'b01;
      for (int k = 0; k <= 12; k++) begin
         step();
         check_all($sformatf("exact4 k=%0d", k), {1'b0, (k >= 5 && k <= 8)},
                   {1'b0, (k == 5)}, {1'b0, (k == 9)});
         if (k == 3) btn_raw = 2'b00;
      end

      // 2-cycle glitch while held: no release, repeat delay restarts
      btn_raw = 2'b01;
      for (int k = 0; k <= 33; k++) begin
         step();
         check_all($sformatf("glitch k=%0d", k), {1'b0, (k >= 5 && k <= 30)},
                   {1'b0, (k == 5 || k == 22 || k == 25)}, {1'b0, (k == 31)});
         btn_raw = {1'b0, ((k < 7 || k >= 9) && k < 25)};
      end

      // reset during WAIT_HIGH, then full debounce with button held
      btn_raw = 2'b01;
      for (int k = 0; k < 4; k++) step();
      reset = 1'b0;
      #1;
      check_all("reset_wait_high", 2'b00, 2'b00, 2'b00);
      step();
      step();
      check_all("reset_held_btn", 2'b00, 2'b00, 2'b00);
      reset = 1'b1;
      for (int k = 0; k <= 15; k++) begin
         step();
         check_all($sformatf("after_reset1 k=%0d", k), {1'b0, (k >= 5)},
                   {1'b0, (k == 5 || k == 15)}, 2'b00);
      end
      // reset while a repeat pulse is high clears outputs asynchronously
      reset = 1'b0;
      #1;
      check_all("reset_mid_repeat", 2'b00, 2'b00, 2'b00);
      step();
      step();
      reset = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         step();
         check_all($sformatf("after_reset2 k=%0d", k), {1'b0, (k >= 5)}, {1'b0, (k == 5)}, 2'b00);
      end
      btn_raw = 2'b00;
      for (int k = 0; k <= 7; k++) begin
         step();
         check_all($sformatf("after_reset2_rel k=%0d", k), {1'b0, (k < 5)}, 2'b00, {1'b0, (k == 5)});
      end

      // both channels together, auto-repeat disabled
      btn_raw2 = 2'b11;
      for (int k = 0; k <= 55; k++) begin
         step();
         check_norep($sformatf("simul k=%0d", k), (k >= 5) ? 2'b11 : 2'b00,
                     (k == 5) ? 2'b11 : 2'b00, 2'b00);
      end
      btn_raw2 = 2'b00;
      for (int k = 0; k <= 7; k++) begin
         step();
         check_norep($sformatf("simul_rel k=%0d", k), (k < 5) ? 2'b11 : 2'b00, 2'b00,
                     (k == 5) ? 2'b11 : 2'b00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
